square: RTL

SQUARE -- requirements
Module: square

---
 rtl/square.sv | 48 ++++
 1 files changed

// File: rtl/square.sv
// square: sequential shift-add squarer, one operand bit per cycle, LSB first.
module square #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   y_in,
  input  logic               y_ready,
  output logic [2*WIDTH-1:0] x_out,
  output logic               x_ready,
  output logic               busy
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0]   op;
  logic [2*WIDTH-1:0] acc, sum;
  logic [CW-1:0]      count;
  logic               last;
  assign last = count == CW'(WIDTH - 1);
  assign sum = acc + (op[count] ? ({{WIDTH{1'b0}}, op} << count) : '0);
  assign x_ready = state == DONE;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE) state_nx = y_ready ? CALC : IDLE;
    else if (state == CALC) state_nx = last ? DONE : CALC;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // Requests seen outside IDLE never touch the operand or result.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      op    <= '0;
      acc   <= '0;
      count <= '0;
      x_out <= '0;
    end else if (state == IDLE && y_ready) begin
      op    <= y_in;
      acc   <= '0;
      count <= '0;
    end else if (state == CALC) begin
      acc   <= sum;
      count <= count + 1'b1;
      if (last) x_out <= sum;
    end
endmodule
